// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I buffered-internal core: fetch/decode/exec/mem/wb sequencing.
// Optional performance counters (cycle_cnt, instret_cnt) are built when CTRL_PERF_CNT_EN is defined.
module rv32i_mc_ctrl #(
  parameter int unsigned RESET_TO_BOOT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_type,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [2:0] ST_RESET = (RESET_TO_BOOT != 0) ? ST_BOOT : ST_FETCH;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALU    = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2 = 2'd0;
  localparam logic [1:0] SRC_B_IMM = 2'd1;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_RFUNCT = 2'd1;
  localparam logic [1:0] ALU_IFUNCT = 2'd2;
  localparam logic [1:0] ALU_BRCMP  = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic       r_illegal;
  logic       w_illegal_nxt;
  logic [2:0] w_imm_type;
  logic       w_legal;

  // funct3 is consumed by the ALU decoder in the datapath, not by the sequencer
  logic w_unused_funct3;
  assign w_unused_funct3 = ^funct3;

  // Opcode decode: immediate format and legality
  always_comb begin
    w_imm_type = IMM_NONE;
    w_legal    = 1'b1;
    case (opcode)
      OP_R:                      w_imm_type = IMM_NONE;
      OP_IMM, OP_LOAD, OP_JALR:  w_imm_type = IMM_I;
      OP_STORE:                  w_imm_type = IMM_S;
      OP_BRANCH:                 w_imm_type = IMM_B;
      OP_LUI, OP_AUIPC:          w_imm_type = IMM_U;
      OP_JAL:                    w_imm_type = IMM_J;
      default:                   w_legal    = 1'b0;
    endcase
  end

  // State and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Next state and datapath controls, decoded from state and opcode
  always_comb begin
    w_state_nxt   = r_state;
    w_illegal_nxt = r_illegal;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = PC_PLUS4;
    imm_type      = IMM_NONE;
    alu_src_a     = SRC_A_RS1;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    reg_we        = 1'b0;
    wb_sel        = WB_ALU;
    halted        = 1'b0;

    case (r_state)
      ST_BOOT: w_state_nxt = ST_FETCH;

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we       = 1'b1;
          pc_we       = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        imm_type = w_imm_type;
        if (w_legal) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt   = ST_HALT;
          w_illegal_nxt = (opcode != OP_SYSTEM);
        end
      end

      ST_EXEC: begin
        w_state_nxt = ST_WB;
        case (opcode)
          OP_R: alu_op = ALU_RFUNCT;
          OP_IMM: begin
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_IFUNCT;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b   = SRC_B_IMM;
            w_state_nxt = ST_MEM;
          end
          OP_LUI: begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = SRC_B_IMM;
          end
          OP_AUIPC: begin
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_IMM;
          end
          OP_BRANCH: begin
            alu_op      = ALU_BRCMP;
            w_state_nxt = ST_FETCH;
            if (branch_taken) begin
              pc_we  = 1'b1;
              pc_sel = PC_BRANCH;
            end
          end
          OP_JAL: begin
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_IMM;
            pc_we     = 1'b1;
            pc_sel    = PC_ALU;
          end
          OP_JALR: begin
            alu_src_b = SRC_B_IMM;
            pc_we     = 1'b1;
            pc_sel    = PC_ALU;
          end
          default: w_state_nxt = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_STORE);
        if (mem_ready) begin
          w_state_nxt = (opcode == OP_STORE) ? ST_FETCH : ST_WB;
        end
      end

      ST_WB: begin
        reg_we      = 1'b1;
        w_state_nxt = ST_FETCH;
        if (opcode == OP_LOAD) begin
          wb_sel = WB_LOAD;
        end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
          wb_sel = WB_LINK;
        end
      end

      ST_HALT: halted = 1'b1;

      default: w_state_nxt = ST_RESET;
    endcase
  end

  assign state   = r_state;
  assign illegal = r_illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;
  logic             w_cycle_inc;
  logic             w_retire;

  assign w_cycle_inc = (r_state != ST_BOOT) && (r_state != ST_HALT);
  assign w_retire    = ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB)) &&
                       (w_state_nxt == ST_FETCH);

  // Free-running counters, wrap at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (w_cycle_inc) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire)    r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt_w;
  assign w_unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Scoreboard bench for rv32i_mc_ctrl: per-cycle expected control vectors are queued per scenario
// and compared against the DUT each cycle.
module tb_rv32i_mc_ctrl;

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [31:0] IR_ADDI  = 32'h00500093;
  localparam logic [31:0] IR_LW    = 32'h0000A103;
  localparam logic [31:0] IR_SW    = 32'h0020A223;
  localparam logic [31:0] IR_BEQ   = 32'h00000463;
  localparam logic [31:0] IR_ADD   = 32'h002081B3;
  localparam logic [31:0] IR_LUI   = 32'h123450B7;
  localparam logic [31:0] IR_AUIPC = 32'h00001097;
  localparam logic [31:0] IR_JAL   = 32'h008000EF;
  localparam logic [31:0] IR_JALR  = 32'h000080E7;
  localparam logic [31:0] IR_ZERO  = 32'h00000000;
  localparam logic [31:0] IR_ECALL = 32'h00000073;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [2:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       reg_we;
    logic [1:0] wb;
    logic       halted;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t       o;
    bit          chk_imm;
    bit          rdy;
    bit          bt;
    logic [31:0] ir;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, halted, illegal;
  logic [1:0] pc_sel, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0] imm_type, state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  rv32i_mc_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .imm_type     (imm_type),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .illegal      (illegal),
    .state        (state)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  function automatic outs_t act_outs();
    outs_t o;
    o.st = state; o.mem_req = mem_req; o.mem_we = mem_we; o.addr_sel = addr_sel;
    o.ir_we = ir_we; o.pc_we = pc_we; o.pc_sel = pc_sel; o.imm = imm_type;
    o.a = alu_src_a; o.b = alu_src_b; o.op = alu_op; o.reg_we = reg_we;
    o.wb = wb_sel; o.halted = halted; o.illegal = illegal;
    return o;
  endfunction

  function automatic outs_t idle(logic [2:0] st);
    outs_t o = '0;
    o.st  = st;
    o.imm = 3'd7;
    return o;
  endfunction

  function automatic void push(outs_t o, bit chk_imm, bit rdy, bit bt, logic [31:0] ir);
    exp_t e;
    e.o = o; e.chk_imm = chk_imm; e.rdy = rdy; e.bt = bt; e.ir = ir;
    sb.push_back(e);
  endfunction

  // FETCH: optional wait cycles, then the handshake cycle
  function automatic void push_fetch(int waits, logic [31:0] ir);
    outs_t o = idle(S_FETCH);
    o.mem_req = 1'b1;
    for (int i = 0; i < waits; i++) push(o, 1'b0, 1'b0, 1'b0, ir);
    o.ir_we = 1'b1;
    o.pc_we = 1'b1;
    push(o, 1'b0, 1'b1, 1'b0, ir);
  endfunction

  function automatic void push_decode(logic [2:0] imm, bit chk_imm, logic [31:0] ir);
    outs_t o = idle(S_DECODE);
    o.imm = imm;
    push(o, chk_imm, 1'b1, 1'b0, ir);
  endfunction

  function automatic void push_exec(logic [1:0] a, logic [1:0] b, logic [1:0] op,
                                    logic pcw, logic [1:0] pcs, bit bt, logic [31:0] ir);
    outs_t o = idle(S_EXEC);
    o.a = a; o.b = b; o.op = op; o.pc_we = pcw; o.pc_sel = pcs;
    push(o, 1'b0, 1'b1, bt, ir);
  endfunction

  function automatic void push_mem(int waits, logic we, logic [31:0] ir);
    outs_t o = idle(S_MEM);
    o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = we;
    for (int i = 0; i < waits; i++) push(o, 1'b0, 1'b0, 1'b0, ir);
    push(o, 1'b0, 1'b1, 1'b0, ir);
  endfunction

  function automatic void push_wb(logic [1:0] wb, logic [31:0] ir);
    outs_t o = idle(S_WB);
    o.reg_we = 1'b1; o.wb = wb;
    push(o, 1'b0, 1'b1, 1'b0, ir);
  endfunction

  function automatic void push_fetch_idle(logic [31:0] ir);
    outs_t o = idle(S_FETCH);
    o.mem_req = 1'b1;
    push(o, 1'b0, 1'b0, 1'b0, ir);
  endfunction

  // Asynchronous reset: outputs must go idle at once, then one BOOT cycle, then FETCH
  task automatic test_reset();
    exp_t  e;
    outs_t a, m;
    int    n = 0;
    rst_n = 1'b0;
    #1;
    a = act_outs();
    checks++;
    if (a !== idle(S_BOOT)) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", a, idle(S_BOOT));
    end
`ifdef CTRL_PERF_CNT_EN
    checks++;
    if ({cycle_cnt, instret_cnt} !== 64'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%h/%h exp=0/0", cycle_cnt, instret_cnt);
    end
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push(idle(S_BOOT), 1'b1, 1'b1, 1'b0, IR_ZERO);
    push_fetch_idle(IR_ZERO);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      opcode = e.ir[6:0]; funct3 = e.ir[14:12]; mem_ready = e.rdy; branch_taken = e.bt;
      #1;
      a = act_outs();
      m = '1;
      if (!e.chk_imm) m.imm = '0;
      checks++;
      if ((a & m) !== (e.o & m)) begin
        failures++;
        $display("FAIL reset_seq cyc%0d got=%h exp=%h", n, a, e.o);
      end
      n++;
    end
  endtask

  task automatic test_addi();
    exp_t  e;
    outs_t a, m;
    int    n = 0;
    push_fetch(0, IR_ADDI);
    push_decode(3'd0, 1'b1, IR_ADDI);
    push_exec(2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 1'b0, IR_ADDI);
    push_wb(2'd0, IR_ADDI);
    push_fetch_idle(IR_ADDI);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      opcode = e.ir[6:0]; funct3 = e.ir[14:12]; mem_ready = e.rdy; branch_taken = e.bt;
      #1;
      a = act_outs();
      m = '1;
      if (!e.chk_imm) m.imm = '0;
      checks++;
      if ((a & m) !== (e.o & m)) begin
        failures++;
        $display("FAIL addi cyc%0d got=%h exp=%h", n, a, e.o);
      end
      n++;
    end
  endtask

  // Load with a two-cycle memory stall in MEM
  task automatic test_load();
    exp_t  e;
    outs_t a, m;
    int    n = 0;
    push_fetch(0, IR_LW);
    push_decode(3'd0, 1'b1, IR_LW);
    push_exec(2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, IR_LW);
    push_mem(2, 1'b0, IR_LW);
    push_wb(2'd1, IR_LW);
    push_fetch_idle(IR_LW);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      opcode = e.ir[6:0]; funct3 = e.ir[14:12]; mem_ready = e.rdy; branch_taken = e.bt;
      #1;
      a = act_outs();
      m = '1;
      if (!e.chk_imm) m.imm = '0;
      checks++;
      if ((a & m) !== (e.o & m)) begin
        failures++;
        $display("FAIL load cyc%0d got=%h exp=%h", n, a, e.o);
      end
      n++;
    end
  endtask

  // Store with one fetch wait; never writes the register file
  task automatic test_store();
    exp_t  e;
    outs_t a, m;
    int    n = 0;
    push_fetch(1, IR_SW);
    push_decode(3'd1, 1'b1, IR_SW);
    push_exec(2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, IR_SW);
    push_mem(0, 1'b1, IR_SW);
    push_fetch_idle(IR_SW);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      opcode = e.ir[6:0]; funct3 = e.ir[14:12]; mem_ready = e.rdy; branch_taken = e.bt;
      #1;
      a = act_outs();
      m = '1;
      if (!e.chk_imm) m.imm = '0;
      checks++;
      if ((a & m) !== (e.o & m)) begin
        failures++;
        $display("FAIL store cyc%0d got=%h exp=%h", n, a, e.o);
      end
      n++;
    end
  endtask

  // BEQ taken then not taken; both retire in three cycles
  task automatic test_branch();
    exp_t  e;
    outs_t a, m;
    int    n = 0;
    push_fetch(0, IR_BEQ);
    push_decode(3'd2, 1'b1, IR_BEQ);
    push_exec(2'd0, 2'd0, 2'd3, 1'b1, 2'd2, 1'b1, IR_BEQ);
    push_fetch(0, IR_BEQ);
    push_decode(3'd2, 1'b1, IR_BEQ);
    push_exec(2'd0, 2'd0, 2'd3, 1'b0, 2'd0, 1'b0, IR_BEQ);
    push_fetch_idle(IR_BEQ);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      opcode = e.ir[6:0]; funct3 = e.ir[14:12]; mem_ready = e.rdy; branch_taken = e.bt;
      #1;
      a = act_outs();
      m = '1;
      if (!e.chk_imm) m.imm = '0;
      checks++;
      if ((a & m) !== (e.o & m)) begin
        failures++;
        $display("FAIL branch cyc%0d got=%h exp=%h", n, a, e.o);
      end
      n++;
    end
  endtask

  // ADD, LUI, AUIPC, JAL (fetch stalls), JALR issued without gaps
  task automatic test_back_to_back();
    exp_t  e;
    outs_t a, m;
    int    n = 0;
    push_fetch(0, IR_ADD);
    push_decode(3'd7, 1'b1, IR_ADD);
    push_exec(2'd0, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, IR_ADD);
    push_wb(2'd0, IR_ADD);
    push_fetch(0, IR_LUI);
    push_decode(3'd3, 1'b1, IR_LUI);
    push_exec(2'd2, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, IR_LUI);
    push_wb(2'd0, IR_LUI);
    push_fetch(0, IR_AUIPC);
    push_decode(3'd3, 1'b1, IR_AUIPC);
    push_exec(2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, IR_AUIPC);
    push_wb(2'd0, IR_AUIPC);
    push_fetch(2, IR_JAL);
    push_decode(3'd4, 1'b1, IR_JAL);
    push_exec(2'd1, 2'd1, 2'd0, 1'b1, 2'd1, 1'b0, IR_JAL);
    push_wb(2'd2, IR_JAL);
    push_fetch(0, IR_JALR);
    push_decode(3'd0, 1'b1, IR_JALR);
    push_exec(2'd0, 2'd1, 2'd0, 1'b1, 2'd1, 1'b0, IR_JALR);
    push_wb(2'd2, IR_JALR);
    push_fetch_idle(IR_JALR);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      opcode = e.ir[6:0]; funct3 = e.ir[14:12]; mem_ready = e.rdy; branch_taken = e.bt;
      #1;
      a = act_outs();
      m = '1;
      if (!e.chk_imm) m.imm = '0;
      checks++;
      if ((a & m) !== (e.o & m)) begin
        failures++;
        $display("FAIL b2b cyc%0d got=%h exp=%h", n, a, e.o);
      end
      n++;
    end
  endtask

  // HALT is absorbing and ignores mem_ready; illegal reflects the decoded opcode
  task automatic test_halt(input logic [31:0] ir, input logic exp_ill, input string tag);
    exp_t  e;
    outs_t a, m, h;
    int    n = 0;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] c0, i0;
`endif
    h = idle(S_HALT);
    h.halted  = 1'b1;
    h.illegal = exp_ill;
    push_fetch(0, ir);
    push_decode(3'd7, 1'b0, ir);
    for (int i = 0; i < 4; i++) push(h, 1'b0, 1'b1, 1'b1, ir);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      opcode = e.ir[6:0]; funct3 = e.ir[14:12]; mem_ready = e.rdy; branch_taken = e.bt;
      #1;
      a = act_outs();
      m = '1;
      if (!e.chk_imm) m.imm = '0;
      checks++;
      if ((a & m) !== (e.o & m)) begin
        failures++;
        $display("FAIL %s cyc%0d got=%h exp=%h", tag, n, a, e.o);
      end
      n++;
`ifdef CTRL_PERF_CNT_EN
      if (n == 3) begin
        c0 = cycle_cnt;
        i0 = instret_cnt;
      end
`endif
    end
`ifdef CTRL_PERF_CNT_EN
    checks++;
    if ({cycle_cnt, instret_cnt} !== {c0, i0}) begin
      failures++;
      $display("FAIL %s_cnt_freeze got=%h/%h exp=%h/%h", tag, cycle_cnt, instret_cnt, c0, i0);
    end
`endif
  endtask

  // Load left pending in MEM; the following reset abandons it
  task automatic test_abort();
    exp_t  e;
    outs_t a, m;
    int    n = 0;
    push_fetch(0, IR_LW);
    push_decode(3'd0, 1'b1, IR_LW);
    push_exec(2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, IR_LW);
    push_mem(2, 1'b0, IR_LW);
    void'(sb.pop_back());
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      opcode = e.ir[6:0]; funct3 = e.ir[14:12]; mem_ready = e.rdy; branch_taken = e.bt;
      #1;
      a = act_outs();
      m = '1;
      if (!e.chk_imm) m.imm = '0;
      checks++;
      if ((a & m) !== (e.o & m)) begin
        failures++;
        $display("FAIL abort cyc%0d got=%h exp=%h", n, a, e.o);
      end
      n++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_addi();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_halt(IR_ZERO, 1'b1, "halt_illegal");
    test_reset();
    test_halt(IR_ECALL, 1'b0, "halt_ecall");
    test_reset();
    test_abort();
    test_reset();
    test_addi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
